k052109_host_bus: RTL
=====================

# k052109_host_bus

Cycle-accurate host CPU bus master for the k052109 simulation benches: the initiator side that drives the chip's address, strobe and bidirectional data pins. It accepts one read or write command per valid/ready handshake, sequences it through setup, strobe, hold and turnaround phases, and returns read data with a one-cycle response pulse. It drives the enable of the chip's data-pin tri-state buffer from the host side, so the chip and the host never drive the bus simultaneously.

## Interface
Parameters:
- AW, 16, address width
- DW, 8, data width
- T_SETUP, 1, cycles address/RWn are valid before CSn falls (1..15)
- T_STROBE, 4, cycles CSn is low (1..15)
- T_HOLD, 1, cycles address/data are held after CSn rises (1..15)
- T_TURN, 1, bus-idle cycles before the next command can be accepted (1..15)

Ports:
- CK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  1  command valid
- REQ_READY  out  1  command accepted when REQ_VALID and REQ_READY are both high
- REQ_RW  in  1  1 = read, 0 = write
- REQ_RMRD  in  1  value driven on RMRD for this access (ROM read select)
- REQ_ADDR  in  AW  access address
- REQ_WDATA  in  DW  write data
- RSP_VALID  out  1  one-cycle pulse, access complete
- RSP_RDATA  out  DW  read data; held until the next read completes
- AB  out  AW  address bus
- CSn  out  1  chip select strobe, active-low
- RWn  out  1  1 = read, 0 = write
- RMRD  out  1  ROM-read select
- DB_OUT  out  DW  host data to bus
- DB_OEn  out  1  host data-bus drive enable, active-low (1 = high-Z)
- DB_IN  in  DW  bus data as seen by host

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN. A shared 4-bit down counter times each phase. It loads T_x−1 on phase entry and exits at 0.
- IDLE: REQ_READY=1 (combinational from state). On handshake, latch ADDR/RW/RMRD/WDATA and go to SETUP. REQ_VALID outside IDLE is ignored, with no side effects.
- SETUP: AB, RWn and RMRD are driven from the latch. For a write, DB_OUT=WDATA and DB_OEn=0. CSn=1.
- STROBE: CSn=0. Other outputs are as in SETUP. For a read, DB_OEn stays 1 throughout.
- Read capture: DB_IN is registered into RSP_RDATA at the rising edge that ends the last STROBE cycle. A write does not modify RSP_RDATA.
- HOLD: CSn=1. AB, RWn, RMRD, DB_OUT and DB_OEn are unchanged from STROBE.
- TURN: DB_OEn=1, RWn=1, CSn=1, RMRD=0. AB and DB_OUT hold their last values. RSP_VALID=1 in the first TURN cycle only. The state returns to IDLE after T_TURN cycles.
- Reset values: CSn=1, RWn=1, DB_OEn=1, RMRD=0, AB=0, DB_OUT=0, RSP_RDATA=0, RSP_VALID=0, state=IDLE (hence REQ_READY=1).
- Reset mid-access: the next edge forces the reset values. No RSP_VALID is issued for the aborted access, and the strobe is never left low.
- Invariant: DB_OEn=0 only while RWn=0. DB_OEn never changes in the same cycle CSn falls.

## Timing
- Handshake at edge t0, in cycle c0.
- SETUP occupies c1..cT_SETUP. STROBE occupies the next T_STROBE cycles, then HOLD occupies T_HOLD cycles, then TURN occupies T_TURN cycles.
- With defaults:
  - CSn is low in c2..c5.
  - Read data is sampled at the end of c5 and valid from c6.
  - RSP_VALID is high in c7.
  - REQ_READY is high again in c8.
- Back-to-back accesses: a new handshake in c8 is accepted, giving an access period of 1+T_SETUP+T_STROBE+T_HOLD+T_TURN cycles (8 with defaults).
- Outputs are registered. The only exception is REQ_READY, which is decoded from state.

## Structure
- Package k052109_host_pkg holds:
  - the state enum
  - the phase-count width constant (4)
  - the RW_READ=1 and RW_WRITE=0 constants
- Sub-module k052109_phase_cnt: a 4-bit synchronous loadable down counter with load, enable and zero flag. It is shared by all phases.
- The top-level module holds the FSM, the command latch and the output registers.

## Test plan
- Reset → all outputs at the reset values listed above; REQ_READY=1. Hold RST high for 3 cycles with REQ_VALID=1 → no access starts.
- Write of addr 0x1C00, data 0xA5 (defaults):
  - AB=0x1C00 and RWn=0 from c1.
  - DB_OEn=0 and DB_OUT=0xA5 in c1..c6.
  - CSn=0 exactly in c2..c5.
  - RSP_VALID in c7; RSP_RDATA unchanged.
- Read of addr 0x0000, with the bench driving DB_IN=0x3C only in c5 and 0xFF elsewhere → RSP_RDATA=0x3C from c6, RSP_VALID in c7, DB_OEn=1 throughout.
- REQ_VALID held high for two commands → second handshake at c8; second CSn falls in c10. Toggling REQ_VALID during c1..c7 has no effect.
- RST asserted in c3 of a write → CSn=1, DB_OEn=1 and state IDLE at the next edge; no RSP_VALID follows.
- T_SETUP=2, T_STROBE=1, T_HOLD=3, T_TURN=2 → CSn low in c3 only, RSP_VALID in c7, REQ_READY in c9.

Source files
------------

// File: rtl/k052109_host_pkg.sv
// Shared types and constants for the k052109 host bus master.
// Holds the phase FSM encoding, the phase counter width and the RW pin polarity.
package k052109_host_pkg;

    localparam int PHASE_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } hostState_t;

endpackage

// File: rtl/k052109_phase_cnt.sv
// Loadable down counter that times every bus phase of the host master.
// A load wins over counting; counting stops at zero and raises the zero flag.
module k052109_phase_cnt
    import k052109_host_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_loadVal,
    output logic               o_zero
);

    logic [PHASE_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/k052109_host_bus.sv
// Host CPU bus master for the k052109: one command per handshake, sequenced
// through setup, strobe, hold and turnaround with fully registered bus outputs.
module k052109_host_bus
    import k052109_host_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 1,
    parameter int T_TURN   = 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_RW,
    input  logic          REQ_RMRD,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [DW-1:0] REQ_WDATA,
    output logic          RSP_VALID,
    output logic [DW-1:0] RSP_RDATA,
    output logic [AW-1:0] AB,
    output logic          CSn,
    output logic          RWn,
    output logic          RMRD,
    output logic [DW-1:0] DB_OUT,
    output logic          DB_OEn,
    input  logic [DW-1:0] DB_IN
);

    localparam logic [PHASE_W-1:0] LD_SETUP  = PHASE_W'(T_SETUP - 1);
    localparam logic [PHASE_W-1:0] LD_STROBE = PHASE_W'(T_STROBE - 1);
    localparam logic [PHASE_W-1:0] LD_HOLD   = PHASE_W'(T_HOLD - 1);
    localparam logic [PHASE_W-1:0] LD_TURN   = PHASE_W'(T_TURN - 1);

    hostState_t         r_state;
    hostState_t         w_nextState;
    logic               w_load;
    logic [PHASE_W-1:0] w_loadVal;
    logic               w_zero;
    logic               w_accept;
    logic               r_cmdRead;
    logic [AW-1:0]      r_ab;
    logic [DW-1:0]      r_dbOut;
    logic [DW-1:0]      r_rdata;
    logic               r_csn;
    logic               r_rwn;
    logic               r_rmrd;
    logic               r_dbOen;
    logic               r_rspValid;

    k052109_phase_cnt u_phaseCnt (
        .i_clk     (CK),
        .i_rst     (RST),
        .i_load    (w_load),
        .i_en      (r_state != ST_IDLE),
        .i_loadVal (w_loadVal),
        .o_zero    (w_zero)
    );

    assign REQ_READY = (r_state == ST_IDLE);
    assign w_accept  = REQ_VALID && REQ_READY;

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        unique case (r_state)
            ST_IDLE: if (REQ_VALID) begin
                w_nextState = ST_SETUP;
                w_load      = 1'b1;
                w_loadVal   = LD_SETUP;
            end
            ST_SETUP: if (w_zero) begin
                w_nextState = ST_STROBE;
                w_load      = 1'b1;
                w_loadVal   = LD_STROBE;
            end
            ST_STROBE: if (w_zero) begin
                w_nextState = ST_HOLD;
                w_load      = 1'b1;
                w_loadVal   = LD_HOLD;
            end
            ST_HOLD: if (w_zero) begin
                w_nextState = ST_TURN;
                w_load      = 1'b1;
                w_loadVal   = LD_TURN;
            end
            ST_TURN: if (w_zero) begin
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Pins change only on phase transitions, so the data driver is always
    // enabled a full phase before the strobe falls and released before TURN.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cmdRead  <= 1'b0;
            r_ab       <= '0;
            r_dbOut    <= '0;
            r_rdata    <= '0;
            r_csn      <= 1'b1;
            r_rwn      <= 1'b1;
            r_rmrd     <= 1'b0;
            r_dbOen    <= 1'b1;
            r_rspValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_rspValid <= 1'b0;
            if (w_accept) begin
                r_cmdRead <= (REQ_RW == RW_READ);
                r_ab      <= REQ_ADDR;
                r_rwn     <= REQ_RW;
                r_rmrd    <= REQ_RMRD;
                if (REQ_RW == RW_WRITE) begin
                    r_dbOut <= REQ_WDATA;
                    r_dbOen <= 1'b0;
                end
            end
            if ((r_state == ST_SETUP) && (w_nextState == ST_STROBE)) begin
                r_csn <= 1'b0;
            end
            if ((r_state == ST_STROBE) && (w_nextState == ST_HOLD)) begin
                r_csn <= 1'b1;
                if (r_cmdRead) begin
                    r_rdata <= DB_IN;
                end
            end
            if ((r_state == ST_HOLD) && (w_nextState == ST_TURN)) begin
                r_dbOen    <= 1'b1;
                r_rwn      <= 1'b1;
                r_rmrd     <= 1'b0;
                r_rspValid <= 1'b1;
            end
        end
    end

    assign RSP_VALID = r_rspValid;
    assign RSP_RDATA = r_rdata;
    assign AB        = r_ab;
    assign CSn       = r_csn;
    assign RWn       = r_rwn;
    assign RMRD      = r_rmrd;
    assign DB_OUT    = r_dbOut;
    assign DB_OEn    = r_dbOen;

endmodule
